// File: rtl/multicycle_control.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB over a shared ALU and one memory port.
// Memory states wait on mem_ready_i and trap after MEM_TIMEOUT idle cycles; outputs are Moore except irwrite/pcwrite.
module multicycle_control #(
   parameter int         MEM_TIMEOUT = 16,
   parameter int         CNT_W       = 32,
   parameter logic [4:0] LINK_REG    = 5'd31
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic [31:0]      instr_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             memread_o,
   output logic             memwrite_o,
   output logic             iord_o,
   output logic             irwrite_o,
   output logic             pcwrite_o,
   output logic [1:0]       pcsrc_o,
   output logic             alusrca_o,
   output logic [1:0]       alusrcb_o,
   output logic             immzext_o,
   output logic [2:0]       alucontrol_o,
   output logic             regwrite_o,
   output logic [4:0]       destreg_o,
   output logic [1:0]       wbsel_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [CNT_W-1:0] retired_o
);

   localparam logic [3:0] S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,  S_WB_R   = 4'd3,
                          S_EXEC_I = 4'd4,  S_WB_I   = 4'd5,  S_MEMADR = 4'd6,  S_MEMRD  = 4'd7,
                          S_MEMWR  = 4'd8,  S_WB_MEM = 4'd9,  S_BRANCH = 4'd10, S_JUMP   = 4'd11,
                          S_JAL    = 4'd12, S_TRAP   = 4'd13;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW    = 6'b101011,
                          OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_ADDIU = 6'b001001,
                          OP_ORI   = 6'b001101, OP_LUI = 6'b001111, OP_J     = 6'b000010,
                          OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADDU = 6'b100001, F_SUBU = 6'b100011, F_AND = 6'b100100,
                          F_OR   = 6'b100101, F_SLTU = 6'b101011, F_JR  = 6'b001000;

   localparam int         TW      = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
   localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

   logic [3:0]       state_q, state_d;
   logic [TW-1:0]    tcnt_q, tcnt_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] retired_q;
   logic             retire;

   logic [5:0] op, funct;
   logic       funct_ok;
   logic       unused_bits;

   assign op          = instr_i[31:26];
   assign funct       = instr_i[5:0];
   assign funct_ok    = funct inside {F_ADDU, F_SUBU, F_AND, F_OR, F_SLTU, F_JR};
   assign unused_bits = ^{instr_i[25:21], instr_i[10:6]};

   always_comb begin
      state_d = state_q;
      tcnt_d  = '0;
      cause_d = cause_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH:  if (mem_ready_i) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_RTYPE:                  state_d = funct_ok ? S_EXEC_R : S_TRAP;
               OP_LW, OP_SW:              state_d = S_MEMADR;
               OP_BEQ, OP_BNE:            state_d = S_BRANCH;
               OP_ADDIU, OP_ORI, OP_LUI:  state_d = S_EXEC_I;
               OP_J:                      state_d = S_JUMP;
               OP_JAL:                    state_d = S_JAL;
               default:                   state_d = S_TRAP;
            endcase
            if (state_d == S_TRAP) cause_d = 2'b01;
         end
         S_EXEC_R: begin
            state_d = (funct == F_JR) ? S_FETCH : S_WB_R;
            retire  = (funct == F_JR);
         end
         S_EXEC_I: state_d = S_WB_I;
         S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (mem_ready_i) state_d = S_WB_MEM;
         S_MEMWR:  if (mem_ready_i) begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JAL: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_FETCH;
      endcase
      // Leaving a wait state always zeroes the counter, so entry always starts from 0.
      if ((state_q inside {S_FETCH, S_MEMRD, S_MEMWR}) && !mem_ready_i) begin
         if (tcnt_q == TO_LAST) begin
            state_d = S_TRAP;
            cause_d = 2'b10;
         end else begin
            tcnt_d = tcnt_q + TW'(1);
         end
      end
   end

   always_comb begin
      memread_o    = 1'b0;
      memwrite_o   = 1'b0;
      iord_o       = 1'b0;
      irwrite_o    = 1'b0;
      pcwrite_o    = 1'b0;
      pcsrc_o      = 2'b00;
      alusrca_o    = 1'b0;
      alusrcb_o    = 2'b00;
      immzext_o    = 1'b0;
      alucontrol_o = 3'b010;
      regwrite_o   = 1'b0;
      destreg_o    = 5'd0;
      wbsel_o      = 2'b00;
      case (state_q)
         S_FETCH: begin
            memread_o = 1'b1;
            alusrcb_o = 2'b01;
            irwrite_o = mem_ready_i;
            pcwrite_o = mem_ready_i;
         end
         S_DECODE: alusrcb_o = 2'b11;
         S_EXEC_R: begin
            alusrca_o = 1'b1;
            case (funct)
               F_SUBU:  alucontrol_o = 3'b110;
               F_AND:   alucontrol_o = 3'b000;
               F_OR:    alucontrol_o = 3'b001;
               F_SLTU:  alucontrol_o = 3'b111;
               F_JR: begin
                  pcsrc_o   = 2'b11;
                  pcwrite_o = 1'b1;
               end
               default: alucontrol_o = 3'b010;
            endcase
         end
         S_WB_R: begin
            regwrite_o = 1'b1;
            destreg_o  = instr_i[15:11];
         end
         S_EXEC_I: begin
            alusrca_o = 1'b1;
            alusrcb_o = 2'b10;
            case (op)
               OP_ORI: begin
                  alucontrol_o = 3'b001;
                  immzext_o    = 1'b1;
               end
               OP_LUI:  alucontrol_o = 3'b100;
               default: alucontrol_o = 3'b010;
            endcase
         end
         S_WB_I: begin
            regwrite_o = 1'b1;
            destreg_o  = instr_i[20:16];
         end
         S_MEMADR: begin
            alusrca_o = 1'b1;
            alusrcb_o = 2'b10;
         end
         S_MEMRD: begin
            iord_o    = 1'b1;
            memread_o = 1'b1;
         end
         S_MEMWR: begin
            iord_o     = 1'b1;
            memwrite_o = 1'b1;
         end
         S_WB_MEM: begin
            regwrite_o = 1'b1;
            destreg_o  = instr_i[20:16];
            wbsel_o    = 2'b01;
         end
         S_BRANCH: begin
            alusrca_o    = 1'b1;
            alucontrol_o = 3'b110;
            pcsrc_o      = 2'b01;
            pcwrite_o    = (op == OP_BNE) ? ~zero_i : zero_i;
         end
         S_JUMP: begin
            pcsrc_o   = 2'b10;
            pcwrite_o = 1'b1;
         end
         S_JAL: begin
            pcsrc_o    = 2'b10;
            pcwrite_o  = 1'b1;
            regwrite_o = 1'b1;
            destreg_o  = LINK_REG;
            wbsel_o    = 2'b10;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= S_FETCH;
         tcnt_q    <= '0;
         cause_q   <= 2'b00;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         tcnt_q  <= tcnt_d;
         cause_q <= cause_d;
         if (retire) retired_q <= retired_q + CNT_W'(1);
      end
   end

   assign trap_o       = (state_q == S_TRAP);
   assign trap_cause_o = cause_q;
   assign retired_o    = retired_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized + directed bench for multicycle_control against a phase-list instruction model.
module tb_multicycle_control;
   localparam int MT = 4;
   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n, zero, mem_ready;
   logic [31:0]   instr;
   logic          memread_o, memwrite_o, iord_o, irwrite_o, pcwrite_o, alusrca_o, immzext_o;
   logic          regwrite_o, trap_o;
   logic [1:0]    pcsrc_o, alusrcb_o, wbsel_o, trap_cause_o;
   logic [2:0]    alucontrol_o;
   logic [4:0]    destreg_o;
   logic [CW-1:0] retired_o;

   multicycle_control #(.MEM_TIMEOUT(MT), .CNT_W(CW), .LINK_REG(5'd31)) dut (
      .clk_i(clk), .reset_ni(reset_n), .instr_i(instr), .zero_i(zero), .mem_ready_i(mem_ready),
      .memread_o(memread_o), .memwrite_o(memwrite_o), .iord_o(iord_o), .irwrite_o(irwrite_o),
      .pcwrite_o(pcwrite_o), .pcsrc_o(pcsrc_o), .alusrca_o(alusrca_o), .alusrcb_o(alusrcb_o),
      .immzext_o(immzext_o), .alucontrol_o(alucontrol_o), .regwrite_o(regwrite_o),
      .destreg_o(destreg_o), .wbsel_o(wbsel_o), .trap_o(trap_o), .trap_cause_o(trap_cause_o),
      .retired_o(retired_o));

   typedef enum int {P_FETCH, P_DEC, P_ALU_R, P_JR, P_WB_R, P_ALU_I, P_WB_I, P_ADDR,
                     P_LD, P_ST, P_WB_LD, P_BR, P_J, P_JAL, P_TRAP} ph_t;

   typedef struct packed {
      logic       memread, memwrite, iord, irwrite, pcwrite;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       immzext;
      logic [2:0] aluctl;
      logic       regwrite;
      logic [4:0] destreg;
      logic [1:0] wbsel;
      logic       trap;
   } outs_t;

   int checks = 0;
   int errors = 0;
   int m_ret = 0;
   logic [1:0] m_cause = 2'b00;

   logic       obs_pcw, obs_rw, obs_tpcw;
   logic [1:0] obs_pcsrc, obs_wbsel, obs_tcause;
   logic [4:0] obs_dest;

   function automatic logic [2:0] r_alu(input logic [5:0] f);
      case (f)
         6'h23:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2b:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   function automatic outs_t expect_out(input ph_t p, input logic [31:0] ins, input logic z,
                                        input logic mr);
      outs_t e;
      e = '0;
      e.aluctl = 3'b010;
      case (p)
         P_FETCH: begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; end
         P_DEC:   e.alusrcb = 2'b11;
         P_ALU_R: begin e.alusrca = 1; e.aluctl = r_alu(ins[5:0]); end
         P_JR:    begin e.alusrca = 1; e.pcsrc = 2'b11; e.pcwrite = 1; end
         P_WB_R:  begin e.regwrite = 1; e.destreg = ins[15:11]; end
         P_ALU_I: begin
            e.alusrca = 1; e.alusrcb = 2'b10;
            e.aluctl  = (ins[31:26] == 6'h0d) ? 3'b001 : (ins[31:26] == 6'h0f) ? 3'b100 : 3'b010;
            e.immzext = (ins[31:26] == 6'h0d);
         end
         P_WB_I:  begin e.regwrite = 1; e.destreg = ins[20:16]; end
         P_ADDR:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
         P_LD:    begin e.iord = 1; e.memread = 1; end
         P_ST:    begin e.iord = 1; e.memwrite = 1; end
         P_WB_LD: begin e.regwrite = 1; e.destreg = ins[20:16]; e.wbsel = 2'b01; end
         P_BR:    begin
            e.alusrca = 1; e.aluctl = 3'b110; e.pcsrc = 2'b01;
            e.pcwrite = (ins[31:26] == 6'h05) ? !z : z;
         end
         P_J:     begin e.pcsrc = 2'b10; e.pcwrite = 1; end
         P_JAL:   begin e.pcsrc = 2'b10; e.pcwrite = 1; e.regwrite = 1; e.destreg = 5'd31;
                        e.wbsel = 2'b10; end
         P_TRAP:  e.trap = 1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // One clock of the model: entered just after a falling edge, leaves at the next one.
   task automatic step(input ph_t p, input logic [31:0] ins, input logic z, input logic mr);
      outs_t e, a;
      instr = ins; zero = z; mem_ready = mr;
      #1;
      e = expect_out(p, ins, z, mr);
      a = '{memread: memread_o, memwrite: memwrite_o, iord: iord_o, irwrite: irwrite_o,
            pcwrite: pcwrite_o, pcsrc: pcsrc_o, alusrca: alusrca_o, alusrcb: alusrcb_o,
            immzext: immzext_o, aluctl: alucontrol_o, regwrite: regwrite_o,
            destreg: destreg_o, wbsel: wbsel_o, trap: trap_o};
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL outputs phase=%s instr=%h actual=%h expected=%h", p.name(), ins, a, e);
      end
      check_eq("trap_cause", int'(trap_cause_o), int'(m_cause));
      check_eq("retired", int'(retired_o), m_ret % (1 << CW));
      obs_pcw = pcwrite_o; obs_pcsrc = pcsrc_o; obs_rw = regwrite_o;
      if (regwrite_o) begin obs_dest = destreg_o; obs_wbsel = wbsel_o; end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      check_eq("rst_memread", int'(memread_o), 1);
      check_eq("rst_iord", int'(iord_o), 0);
      check_eq("rst_retired", int'(retired_o), 0);
      check_eq("rst_trap", int'(trap_o), 0);
      check_eq("rst_cause", int'(trap_cause_o), 0);
      @(negedge clk);
      reset_n = 1'b1;
      m_ret = 0;
      m_cause = 2'b00;
   endtask

   task automatic trap_hold();
      obs_tpcw = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(P_TRAP, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         obs_tpcw = obs_tpcw | obs_pcw;
      end
      obs_tcause = trap_cause_o;
      do_reset();
   endtask

   // df/dm: not-ready cycles before mem_ready in FETCH / MEMRD-MEMWR; negative = random.
   task automatic run_instr(input logic [31:0] ins, input int zmode, input int df, input int dm,
                            output int cyc, output bit trapped);
      ph_t q[$];
      logic [5:0] op, fn;
      logic z, mr;
      int waits, d;
      op = ins[31:26]; fn = ins[5:0];
      q = {P_FETCH, P_DEC};
      if (op == 6'h00) begin
         if (fn == 6'h08) q.push_back(P_JR);
         else if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2b}) begin
            q.push_back(P_ALU_R); q.push_back(P_WB_R);
         end else q.push_back(P_TRAP);
      end
      else if (op == 6'h23) begin q.push_back(P_ADDR); q.push_back(P_LD); q.push_back(P_WB_LD); end
      else if (op == 6'h2b) begin q.push_back(P_ADDR); q.push_back(P_ST); end
      else if (op inside {6'h04, 6'h05}) q.push_back(P_BR);
      else if (op inside {6'h09, 6'h0d, 6'h0f}) begin q.push_back(P_ALU_I); q.push_back(P_WB_I); end
      else if (op == 6'h02) q.push_back(P_J);
      else if (op == 6'h03) q.push_back(P_JAL);
      else q.push_back(P_TRAP);
      cyc = 0;
      trapped = 0;
      foreach (q[k]) begin
         if (q[k] == P_TRAP) begin
            m_cause = 2'b01;
            trapped = 1;
            trap_hold();
            return;
         end
         d = (q[k] == P_FETCH) ? df : dm;
         waits = 0;
         forever begin
            z = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            if (q[k] inside {P_FETCH, P_LD, P_ST})
               mr = (d < 0) ? ($urandom_range(0, 9) < 6) : (waits >= d);
            else
               mr = 1'($urandom_range(0, 1));
            step(q[k], ins, z, mr);
            cyc++;
            if (!(q[k] inside {P_FETCH, P_LD, P_ST}) || mr) break;
            waits++;
            if (waits == MT) begin
               m_cause = 2'b10;
               trapped = 1;
               trap_hold();
               return;
            end
         end
      end
      m_ret = (m_ret + 1) % (1 << CW);
   endtask

   logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h09, 6'h0d, 6'h0f, 6'h02, 6'h03};
   logic [5:0] fns [6]  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2b, 6'h08};

   initial begin
      int cyc;
      bit tr;
      logic [31:0] ins;
      reset_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      do_reset();

      run_instr(32'h00221821, 0, 0, 0, cyc, tr);
      check_eq("addu_cycles", cyc, 4);
      check_eq("addu_destreg", int'(obs_dest), 3);
      check_eq("addu_retired", int'(retired_o), 1);

      run_instr(32'h8C850008, 0, 0, 3, cyc, tr);
      check_eq("lw_cycles", cyc, 8);
      check_eq("lw_destreg", int'(obs_dest), 5);
      check_eq("lw_wbsel", int'(obs_wbsel), 1);

      run_instr(32'h10220004, 1, 0, 0, cyc, tr);
      check_eq("beq_pcwrite", int'(obs_pcw), 1);
      check_eq("beq_pcsrc", int'(obs_pcsrc), 1);
      check_eq("beq_cycles", cyc, 3);
      run_instr(32'h14220004, 1, 0, 0, cyc, tr);
      check_eq("bne_pcwrite", int'(obs_pcw), 0);

      run_instr(32'h0C000010, 0, 0, 0, cyc, tr);
      check_eq("jal_regwrite", int'(obs_rw), 1);
      check_eq("jal_destreg", int'(obs_dest), 31);
      check_eq("jal_wbsel", int'(obs_wbsel), 2);
      check_eq("jal_pcsrc", int'(obs_pcsrc), 2);
      check_eq("jal_pcwrite", int'(obs_pcw), 1);

      run_instr(32'hFC000000, 0, 0, 0, cyc, tr);
      check_eq("illegal_trapped", int'(tr), 1);
      check_eq("illegal_cause", int'(obs_tcause), 1);
      check_eq("illegal_pcwrite", int'(obs_tpcw), 0);

      run_instr(32'h00221821, 0, 4, 0, cyc, tr);
      check_eq("timeout_trapped", int'(tr), 1);
      check_eq("timeout_cycles", cyc, 4);
      check_eq("timeout_cause", int'(obs_tcause), 2);
      run_instr(32'h00221821, 0, 3, 0, cyc, tr);
      check_eq("late_ready_trapped", int'(tr), 0);
      check_eq("late_ready_cycles", cyc, 7);

      // Asynchronous reset while a load is waiting in MEMRD.
      step(P_FETCH, 32'h8C850008, 1'b0, 1'b1);
      step(P_DEC,   32'h8C850008, 1'b0, 1'b0);
      step(P_ADDR,  32'h8C850008, 1'b0, 1'b0);
      mem_ready = 1'b0;
      #1;
      check_eq("memrd_memread", int'(memread_o), 1);
      check_eq("memrd_iord", int'(iord_o), 1);
      #2;
      do_reset();

      for (int i = 0; i < 15; i++) run_instr(32'h08000000 | ($urandom & 32'h03FFFFFF), 0, 0, 0, cyc, tr);
      check_eq("retired_max", int'(retired_o), 15);
      run_instr(32'h08000004, 0, 0, 0, cyc, tr);
      check_eq("retired_wrap", int'(retired_o), 0);

      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         if ($urandom_range(0, 99) >= 8) ins[31:26] = ops[$urandom_range(0, 9)];
         if (ins[31:26] == 6'h00 && $urandom_range(0, 99) >= 10) ins[5:0] = fns[$urandom_range(0, 5)];
         run_instr(ins, 2, -1, -1, cyc, tr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Parametrised multi-cycle control unit that supersedes the single-cycle combinational instruction decoder for the MIPS subset processor. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states over a shared ALU and a single memory port with a ready handshake. It adds instruction-set coverage (bne, ori, lui, jal, jr), a memory-timeout trap and a retired-instruction counter. It sits between the instruction register and the datapath muxes.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory state before trapping (>=1)
CNT_W, 32, width of retired-instruction counter
LINK_REG, 31, destination register number written by jal

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 forces the reset state immediately
instr  in  32  current instruction register contents (op=[31:26], funct=[5:0])
zero  in  1  ALU result equals zero
mem_ready  in  1  memory completes the current access this cycle
memread / memwrite  out  1 each  memory access request (held until mem_ready)
iord  out  1  0=address from PC, 1=address from ALUOut
irwrite  out  1  load instruction register
pcwrite  out  1  write PC (already gated with branch condition)
pcsrc  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 register rs
alusrca  out  1  0=PC, 1=register A
alusrcb  out  2  00 B, 01 constant 4, 10 extended imm, 11 sign-ext imm<<2
immzext  out  1  1=zero-extend imm (ori), 0=sign-extend
alucontrol  out  3  000 and, 001 or, 010 add, 110 sub, 111 sltu, 100 lui (imm<<16)
regwrite  out  1  write register file
destreg  out  5  destination register number
wbsel  out  2  00 ALUOut, 01 memory data, 10 PC (link)
trap  out  1  sticky error flag
trap_cause  out  2  00 none, 01 illegal opcode/funct, 10 memory timeout
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (reset=0, async): state=FETCH, retired=0, trap=0, trap_cause=00, timeout counter=0. All outputs are decoded from state (Moore) except as noted; undriven controls are 0 (destreg=0, alucontrol=010).
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, alucontrol=010, pcsrc=00. irwrite=pcwrite=mem_ready. Stay until mem_ready, then go to DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=010 (branch target into ALUOut). Next state by op: 000000 -> EXEC_R (funct must be addu 100001, subu 100011, and 100100, or 100101, sltu 101011 or jr 001000), 100011/101011 -> MEMADR, 000100/000101 -> BRANCH, 001001/001101/001111 -> EXEC_I, 000010 -> JUMP, 000011 -> JAL. Any other op or funct -> TRAP, cause 01.
- EXEC_R: alusrca=1, alusrcb=00, alucontrol from funct per encoding above -> WB_R. jr instead: pcsrc=11, pcwrite=1 -> FETCH (retires).
- WB_R: regwrite=1, destreg=instr[15:11], wbsel=00 -> FETCH.
- EXEC_I: alusrca=1, alusrcb=10; addiu alucontrol=010, ori 001 with immzext=1, lui 100 -> WB_I. WB_I: regwrite=1, destreg=instr[20:16], wbsel=00 -> FETCH.
- MEMADR: alusrca=1, alusrcb=10, alucontrol=010 -> MEMRD (lw) or MEMWR (sw).
- MEMRD/MEMWR: iord=1, memread or memwrite=1 until mem_ready. MEMRD -> WB_MEM, MEMWR -> FETCH. WB_MEM: regwrite=1, destreg=instr[20:16], wbsel=01 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01; pcwrite=zero (beq) or ~zero (bne) -> FETCH.
- JUMP: pcsrc=10, pcwrite=1 -> FETCH. JAL: same, plus regwrite=1, destreg=LINK_REG, wbsel=10 -> FETCH.
- Latency excluding memory wait: beq/bne/j/jal/jr 3 cycles, R-type/I-type/sw 4, lw 5. Each memory wait cycle adds one cycle.
- retired increments by 1 on the final-state cycle of each instruction and wraps at 2^CNT_W to 0. It is not incremented in TRAP.
- Timeout: the counter clears on entry to FETCH/MEMRD/MEMWR and increments each cycle mem_ready=0 in those states. When mem_ready=0 with counter==MEM_TIMEOUT-1 -> TRAP, cause 10. mem_ready=1 on that same cycle wins and the access completes normally.
- TRAP: all write/request outputs 0, trap=1, holds until reset. trap_cause is written once on entry.

Test Plan:
- Reset low mid-MEMRD with memread=1 -> same cycle state=FETCH, memread=1, iord=0, retired=0, trap=0.
- addu $3,$1,$2 (0x00221821), mem_ready always 1 -> 4 cycles, WB_R regwrite=1, destreg=3, alucontrol=010, retired +1.
- lw $5,8($4) with mem_ready delayed 3 cycles in MEMRD -> 8 cycles total, WB_MEM destreg=5, wbsel=01.
- beq with zero=1 then bne with zero=1 -> pcwrite=1 then pcwrite=0 in BRANCH, pcsrc=01.
- jal -> regwrite=1, destreg=31, wbsel=10, pcsrc=10, pcwrite=1. Opcode 111111 -> TRAP, trap_cause=01, no further pcwrite.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP after 4 cycles, cause 10. Repeat with mem_ready=1 on cycle 4 -> no trap. Preload retired=2^CNT_W-1 (CNT_W=4) -> wraps to 0.
